// File: rtl/b01_serial_scheduler_if.sv
// Request/response bundle between the requester fabric and b01_serial_scheduler.
//   req_valid/req_ready : per-requester handshake (req_ready one-hot or zero)
//   req_a/req_b         : packed operands, requester i at [i*WORD_W +: WORD_W]
//   rsp_valid/rsp_ready : response handshake
//   rsp_id/rsp_data/rsp_ovf : response payload
// master = requester fabric side, slave = scheduler side.
interface b01_serial_scheduler_if #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned WORD_W = 8
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*WORD_W-1:0] req_a;
    logic [NREQ*WORD_W-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IW-1:0]          rsp_id;
    logic [WORD_W-1:0]      rsp_data;
    logic                   rsp_ovf;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf
    );
endinterface

// File: rtl/b01_serial_scheduler.sv
// Round-robin scheduler sharing one bit-serial b01 core among NREQ requesters.
// Each granted request clears the core, shifts both operands LSB-first onto
// the core lines, collects WORD_W output bits plus an overflow OR, and returns
// them on the response port.
//   clock, reset_n : rising-edge clock, async active-low reset
//   bus            : request/response bundle (slave side)
//   core_line1/2   : registered serial operand bits to the core
//   core_clr       : registered synchronous clear to the core
//   core_outp/ovf  : core serial output and overflow flag
module b01_serial_scheduler #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned WORD_W   = 8,
    parameter int unsigned CORE_LAT = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    b01_serial_scheduler_if.slave  bus,
    output logic                   core_line1,
    output logic                   core_line2,
    output logic                   core_clr,
    input  logic                   core_outp,
    input  logic                   core_ovf
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(WORD_W + CORE_LAT + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SHIFT, S_DRAIN, S_RESP} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     id_q, id_d;
    logic [WORD_W-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WORD_W-1:0] acc_data_q, acc_data_d;
    logic              acc_ovf_q, acc_ovf_d;
    logic              arm_q;
    logic              line1_q, line1_d, line2_q, line2_d, clr_q, clr_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_ovf_q, rsp_ovf_d;
    logic [IW-1:0]     rsp_id_q, rsp_id_d;
    logic [WORD_W-1:0] rsp_data_q, rsp_data_d;

    logic              grant_vld_c;
    logic [IW-1:0]     grant_c;
    logic [WORD_W-1:0] sel_a_c, sel_b_c;
    logic [NREQ-1:0]   req_ready_c;
    int unsigned       dist_c, best_c;

    // Round-robin arbiter: smallest distance above the last winner wins.
    always_comb begin
        grant_c = '0;
        sel_a_c = '0;
        sel_b_c = '0;
        dist_c  = 0;
        best_c  = NREQ;
        for (int unsigned j = 0; j < NREQ; j++) begin
            dist_c = (j + NREQ - 32'(ptr_q) - 1) % NREQ;
            if (bus.req_valid[j] && (dist_c < best_c)) begin
                best_c  = dist_c;
                grant_c = IW'(j);
                sel_a_c = bus.req_a[j*WORD_W +: WORD_W];
                sel_b_c = bus.req_b[j*WORD_W +: WORD_W];
            end
        end
        grant_vld_c = (best_c < NREQ);
        // arm_q keeps req_ready low while reset is asserted.
        req_ready_c = (state_q == S_IDLE && arm_q && grant_vld_c) ?
                      (NREQ'(1) << grant_c) : '0;
    end

    assign bus.req_ready = req_ready_c;

    // Next state, datapath and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        cnt_d       = cnt_q;
        acc_data_d  = acc_data_q;
        acc_ovf_d   = acc_ovf_q;
        line1_d     = 1'b0;
        line2_d     = 1'b0;
        clr_d       = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = '0;
        rsp_data_d  = '0;
        rsp_ovf_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arm_q && grant_vld_c) begin
                    a_sr_d     = sel_a_c;
                    b_sr_d     = sel_b_c;
                    id_d       = grant_c;
                    ptr_d      = grant_c;
                    acc_data_d = '0;
                    acc_ovf_d  = 1'b0;
                    state_d    = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WORD_W - 1)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WORD_W + CORE_LAT - 1)) state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // cnt_q counts cycles since the first SHIFT cycle; bit k returns at cnt k+CORE_LAT.
        if ((state_q == S_SHIFT || state_q == S_DRAIN) && (cnt_q >= CW'(CORE_LAT))) begin
            acc_data_d = acc_data_q | (WORD_W'(core_outp) << (cnt_q - CW'(CORE_LAT)));
            acc_ovf_d  = acc_ovf_q | core_ovf;
        end

        // Lines are registered, so the next bit is presented one cycle early.
        if (state_d == S_SHIFT) begin
            line1_d = a_sr_q[0];
            line2_d = b_sr_q[0];
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
        end

        clr_d = (state_d == S_CLEAR);

        if (state_d == S_RESP) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
            rsp_data_d  = acc_data_d;
            rsp_ovf_d   = acc_ovf_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= IW'(NREQ - 1);
            id_q        <= '0;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            cnt_q       <= '0;
            acc_data_q  <= '0;
            acc_ovf_q   <= 1'b0;
            arm_q       <= 1'b0;
            line1_q     <= 1'b0;
            line2_q     <= 1'b0;
            clr_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            cnt_q       <= cnt_d;
            acc_data_q  <= acc_data_d;
            acc_ovf_q   <= acc_ovf_d;
            arm_q       <= 1'b1;
            line1_q     <= line1_d;
            line2_q     <= line2_d;
            clr_q       <= clr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ovf_q   <= rsp_ovf_d;
        end
    end

    assign core_line1   = line1_q;
    assign core_line2   = line2_q;
    assign core_clr     = clr_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_ovf   = rsp_ovf_q;
endmodule

// File: tb/tb_b01_serial_scheduler.sv
// Self-checking bench for b01_serial_scheduler: a default instance (4 req,
// 8-bit, latency 1) and a wide instance (2 req, 16-bit, latency 3), each with
// a behavioural core stub (outp = l1^l2, ovf = l1&l2, CORE_LAT cycles later).
module tb_b01_serial_scheduler;
    localparam int unsigned NR  = 4;
    localparam int unsigned WA  = 8;
    localparam int unsigned LA  = 1;
    localparam int unsigned NRB = 2;
    localparam int unsigned WB  = 16;
    localparam int unsigned LB  = 3;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    b01_serial_scheduler_if #(.NREQ(NR),  .WORD_W(WA)) bus_a();
    b01_serial_scheduler_if #(.NREQ(NRB), .WORD_W(WB)) bus_b();

    logic a_l1, a_l2, a_clr, a_outp, a_ovf;
    logic b_l1, b_l2, b_clr, b_outp, b_ovf;

    b01_serial_scheduler #(.NREQ(NR), .WORD_W(WA), .CORE_LAT(LA)) dut_a (
        .clock(clock), .reset_n(reset_n), .bus(bus_a.slave),
        .core_line1(a_l1), .core_line2(a_l2), .core_clr(a_clr),
        .core_outp(a_outp), .core_ovf(a_ovf));

    b01_serial_scheduler #(.NREQ(NRB), .WORD_W(WB), .CORE_LAT(LB)) dut_b (
        .clock(clock), .reset_n(reset_n), .bus(bus_b.slave),
        .core_line1(b_l1), .core_line2(b_l2), .core_clr(b_clr),
        .core_outp(b_outp), .core_ovf(b_ovf));

    // Core stubs: CORE_LAT-deep pipes cleared by core_clr.
    logic [LA-1:0] a_po, a_pv;
    logic [LB-1:0] b_po, b_pv;
    always @(posedge clock) begin
        if (!reset_n || a_clr) begin
            a_po <= '0; a_pv <= '0;
        end else begin
            a_po <= (a_po << 1) | LA'(a_l1 ^ a_l2);
            a_pv <= (a_pv << 1) | LA'(a_l1 & a_l2);
        end
        if (!reset_n || b_clr) begin
            b_po <= '0; b_pv <= '0;
        end else begin
            b_po <= (b_po << 1) | LB'(b_l1 ^ b_l2);
            b_pv <= (b_pv << 1) | LB'(b_l1 & b_l2);
        end
    end
    assign a_outp = a_po[LA-1];
    assign a_ovf  = a_pv[LA-1];
    assign b_outp = b_po[LB-1];
    assign b_ovf  = b_pv[LB-1];

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state for the default instance.
    int          ptr_m;
    bit          pend [NR];
    logic [WA-1:0] pa [NR];
    logic [WA-1:0] pb [NR];
    int          g_log [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR-1:0] pend_vec();
        logic [NR-1:0] v;
        for (int i = 0; i < NR; i++) v[i] = pend[i];
        return v;
    endfunction

    // Round-robin rule: first pending requester after the last winner.
    function automatic int pick(input int ptr, input logic [NR-1:0] v);
        for (int o = 1; o <= NR; o++) begin
            if (v[(ptr + o) % NR]) return (ptr + o) % NR;
        end
        return -1;
    endfunction

    task automatic drive_a();
        for (int i = 0; i < NR; i++) begin
            bus_a.req_valid[i]         = pend[i];
            bus_a.req_a[i*WA +: WA]    = pa[i];
            bus_a.req_b[i*WA +: WA]    = pb[i];
        end
    endtask

    // One full transaction on the default instance; entered and left near a negedge.
    task automatic run_one(input int hold);
        int eg, lat;
        bit seen, busy_ok, clr_ok, stab_ok;
        logic [WA-1:0] ed;
        logic eo;
        eg = pick(ptr_m, pend_vec());
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus_a.req_ready != '0) begin seen = 1'b1; break; end
            @(negedge clock);
        end
        chk("grant_seen", 32'(seen), 32'd1);
        if (!seen || eg < 0) return;
        chk("grant_onehot", 32'(bus_a.req_ready), 32'd1 << eg);
        ed = pa[eg] ^ pb[eg];
        eo = |(pa[eg] & pb[eg]);
        g_log.push_back(eg);
        @(posedge clock); #1;
        pend[eg] = 1'b0;
        pa[eg] = WA'($urandom);
        pb[eg] = WA'($urandom);
        drive_a();
        ptr_m = eg;
        bus_a.rsp_ready = (hold == 0);
        @(negedge clock);
        chk("clear_pulse", 32'(a_clr), 32'd1);
        busy_ok = (bus_a.req_ready == '0);
        clr_ok = 1'b1;
        lat = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clock); @(negedge clock);
            if (bus_a.req_ready != '0) busy_ok = 1'b0;
            if (a_clr) clr_ok = 1'b0;
            if (bus_a.rsp_valid) begin lat = c; break; end
        end
        chk("rsp_latency", 32'(lat), 32'(1 + WA + LA));
        chk("busy_no_ready", 32'(busy_ok), 32'd1);
        chk("clear_single", 32'(clr_ok), 32'd1);
        chk("rsp_id", 32'(bus_a.rsp_id), 32'(eg));
        chk("rsp_data", 32'(bus_a.rsp_data), 32'(ed));
        chk("rsp_ovf", 32'(bus_a.rsp_ovf), 32'(eo));
        stab_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(posedge clock); @(negedge clock);
            if (!bus_a.rsp_valid || bus_a.rsp_id != 2'(eg) || bus_a.rsp_data != ed ||
                bus_a.rsp_ovf != eo || bus_a.req_ready != '0) stab_ok = 1'b0;
        end
        if (hold > 0) chk("rsp_hold_stable", 32'(stab_ok), 32'd1);
        bus_a.rsp_ready = 1'b1;
        @(posedge clock); #1;
        bus_a.rsp_ready = 1'b0;
        @(negedge clock);
        chk("rsp_valid_drop", 32'(bus_a.rsp_valid), 32'd0);
        chk("rsp_data_idle", 32'(bus_a.rsp_data), 32'd0);
    endtask

    // One transaction on the wide instance, response accepted immediately.
    task automatic run_b(input int id, input logic [WB-1:0] a, input logic [WB-1:0] b);
        int lat;
        bit seen;
        bus_b.req_valid = '0;
        bus_b.req_valid[id] = 1'b1;
        bus_b.req_a[id*WB +: WB] = a;
        bus_b.req_b[id*WB +: WB] = b;
        bus_b.rsp_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus_b.req_ready != '0) begin seen = 1'b1; break; end
            @(negedge clock);
        end
        chk("b_grant", 32'(bus_b.req_ready), 32'd1 << id);
        if (!seen) return;
        @(posedge clock); #1;
        bus_b.req_valid = '0;
        bus_b.req_a[id*WB +: WB] = ~a;
        @(negedge clock);
        chk("b_clear_pulse", 32'(b_clr), 32'd1);
        lat = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clock); @(negedge clock);
            if (bus_b.rsp_valid) begin lat = c; break; end
        end
        chk("b_rsp_latency", 32'(lat), 32'(1 + WB + LB));
        chk("b_rsp_id", 32'(bus_b.rsp_id), 32'(id));
        chk("b_rsp_data", 32'(bus_b.rsp_data), 32'(a ^ b));
        chk("b_rsp_ovf", 32'(bus_b.rsp_ovf), 32'(|(a & b)));
        @(posedge clock); #1;
        bus_b.rsp_ready = 1'b0;
        @(negedge clock);
        chk("b_rsp_valid_drop", 32'(bus_b.rsp_valid), 32'd0);
    endtask

    initial begin
        int eg;
        bit seen;
        logic [WA-1:0] a_save;
        logic [NR-1:0] mask;

        bus_a.req_valid = '0; bus_a.req_a = '0; bus_a.req_b = '0; bus_a.rsp_ready = 1'b0;
        bus_b.req_valid = '0; bus_b.req_a = '0; bus_b.req_b = '0; bus_b.rsp_ready = 1'b0;
        ptr_m = NR - 1;

        // Reset state with all four requesters already valid (A=0x01, B=0x02).
        for (int i = 0; i < NR; i++) begin pend[i] = 1'b1; pa[i] = 8'h01; pb[i] = 8'h02; end
        drive_a();
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_req_ready", 32'(bus_a.req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        chk("reset_core_clr", 32'(a_clr), 32'd0);
        chk("reset_line1", 32'(a_l1), 32'd0);
        chk("reset_rsp_data", 32'(bus_a.rsp_data), 32'd0);
        chk("reset_b_rsp_valid", 32'(bus_b.rsp_valid), 32'd0);
        reset_n = 1'b1;

        // All valid from reset: grants 0,1,2,3.
        for (int k = 0; k < NR; k++) run_one(0);
        for (int k = 0; k < NR; k++) chk("rr_order", 32'(g_log[k]), 32'(k));

        // Single request from requester 2.
        pend[2] = 1'b1; pa[2] = 8'h5A; pb[2] = 8'h0F; drive_a();
        run_one(0);

        // Backpressure with a second requester waiting.
        pend[1] = 1'b1; pa[1] = WA'($urandom); pb[1] = WA'($urandom);
        pend[3] = 1'b1; pa[3] = WA'($urandom); pb[3] = WA'($urandom);
        drive_a();
        run_one(5);
        run_one(0);

        // Overflow boundaries.
        pend[0] = 1'b1; pa[0] = 8'hF0; pb[0] = 8'h0F; drive_a();
        run_one(0);
        pend[0] = 1'b1; pa[0] = 8'h80; pb[0] = 8'h80; drive_a();
        run_one(2);

        // Reset during SHIFT bit 4.
        pend[2] = 1'b1; pa[2] = WA'($urandom); pb[2] = WA'($urandom); drive_a();
        a_save = pa[2];
        eg = pick(ptr_m, pend_vec());
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus_a.req_ready != '0) begin seen = 1'b1; break; end
            @(negedge clock);
        end
        chk("abort_grant", 32'(bus_a.req_ready), 32'd1 << eg);
        @(posedge clock); #1;
        pend[2] = 1'b0; drive_a();
        repeat (5) @(posedge clock);
        #1;
        chk("shift_bit4_line1", 32'(a_l1), 32'(a_save[4]));
        pend[1] = 1'b1; pa[1] = WA'($urandom); pb[1] = WA'($urandom);
        pend[3] = 1'b1; pa[3] = WA'($urandom); pb[3] = WA'($urandom);
        drive_a();
        reset_n = 1'b0;
        #1;
        chk("abort_line1", 32'(a_l1), 32'd0);
        chk("abort_line2", 32'(a_l2), 32'd0);
        chk("abort_core_clr", 32'(a_clr), 32'd0);
        chk("abort_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        chk("abort_req_ready", 32'(bus_a.req_ready), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        ptr_m = NR - 1;
        run_one(0);
        chk("post_reset_first", 32'(g_log[g_log.size()-1]), 32'd1);
        run_one(0);
        chk("post_reset_second", 32'(g_log[g_log.size()-1]), 32'd3);

        // Randomised request sets against the round-robin model.
        for (int r = 0; r < 6; r++) begin
            mask = NR'($urandom_range(1, (1 << NR) - 1));
            for (int i = 0; i < NR; i++) begin
                if (mask[i]) begin
                    pend[i] = 1'b1; pa[i] = WA'($urandom); pb[i] = WA'($urandom);
                end
            end
            drive_a();
            for (int k = 0; k < NR; k++) begin
                if (pend_vec() != '0) run_one(int'($urandom_range(0, 3)));
            end
        end

        // Wide instance: 16-bit words, latency 3.
        run_b(0, 16'hA5A5, 16'h0000);
        for (int k = 0; k < 3; k++)
            run_b(int'($urandom_range(0, NRB - 1)), WB'($urandom), WB'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
